// File: rtl/param_seq_detect.sv
// Serial bit-pattern detector with a runtime-loadable PAT_W-bit pattern,
// selectable Mealy/Moore output, optional overlapping matches and a saturating match counter.
module param_seq_detect #(
  parameter int unsigned      PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1101),
  parameter int unsigned      CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             mode_moore,
  input  logic             overlap,
  input  logic             count_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              z_q, z_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;

  logic              beat_c;
  logic              match_c;
  logic [PAT_W-1:0]  hist_shift_c;
  logic [FILL_W-1:0] fill_inc_c;

  // Candidate history for this beat; a load cycle swallows any beat.
  always_comb begin
    beat_c       = din_valid & ~pat_load;
    hist_shift_c = {hist_q[PAT_W-2:0], din};
    fill_inc_c   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    match_c      = beat_c && (fill_inc_c == FILL_FULL) && (hist_shift_c == pat_q);
  end

  // Next-state: pattern/history update and saturating counter.
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    z_d    = match_c;
    cnt_d  = cnt_q;
    sat_d  = sat_q;

    if (pat_load) begin
      pat_d  = pattern;
      hist_d = '0;
      fill_d = '0;
    end else if (beat_c) begin
      if (match_c && !overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_shift_c;
        fill_d = fill_inc_c;
      end
    end

    if (count_clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (match_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
      sat_d = sat_q | (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q  <= DEFAULT_PAT;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  // fill is zero in reset, so the Mealy path cannot fire while reset is held.
  assign z           = mode_moore ? z_q : match_c;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;

endmodule

// File: tb/tb_param_seq_detect.sv
// Directed bench for param_seq_detect: default-width instance plus a CNT_W=2 instance
// sharing the same stimulus; expected z pulses go through a scoreboard queue.
module tb_param_seq_detect;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_valid, din, pat_load, mode_moore, overlap, count_clr;
  logic [3:0] pattern;
  logic       z1, z2, sat_o1, sat_o2;
  logic [7:0] cnt_o1;
  logic [1:0] cnt_o2;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   sn     = 0;
  int   cnt1   = 0;
  int   cnt2   = 0;
  logic sat2   = 1'b0;
  string ctx   = "init";
  logic  sb[$];

  always #5 clk = ~clk;

  param_seq_detect u_dut (
    .clk(clk), .reset(rst_n), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pattern(pattern), .mode_moore(mode_moore), .overlap(overlap), .count_clr(count_clr),
    .z(z1), .match_count(cnt_o1), .count_sat(sat_o1)
  );

  param_seq_detect #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(rst_n), .din_valid(din_valid), .din(din), .pat_load(pat_load),
    .pattern(pattern), .mode_moore(mode_moore), .overlap(overlap), .count_clr(count_clr),
    .z(z2), .match_count(cnt_o2), .count_sat(sat_o2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts();
    chk($sformatf("%s.%0d count", ctx, sn), 32'(cnt_o1), 32'(cnt1));
    chk($sformatf("%s.%0d count2", ctx, sn), 32'(cnt_o2), 32'(cnt2));
    chk($sformatf("%s.%0d sat", ctx, sn), 32'(sat_o1), 32'd0);
    chk($sformatf("%s.%0d sat2", ctx, sn), 32'(sat_o2), 32'(sat2));
  endtask

  // One clock cycle, starting and ending at a falling edge.
  task automatic step(input logic v, input logic d, input logic m,
                      input logic ld = 1'b0, input logic clr = 1'b0);
    logic e;
    din_valid = v;
    din       = d;
    pat_load  = ld;
    count_clr = clr;
    sb.push_back(m);
    sn++;
    #1;
    if (!mode_moore) begin
      e = sb.pop_front();
      chk($sformatf("%s.%0d mealy z", ctx, sn), 32'(z1), 32'(e));
      chk($sformatf("%s.%0d mealy z2", ctx, sn), 32'(z2), 32'(e));
    end
    if (clr) begin
      cnt1 = 0;
      cnt2 = 0;
      sat2 = 1'b0;
    end else if (m) begin
      if (cnt1 < 255) cnt1++;
      if (cnt2 < 3) cnt2++;
      if (cnt2 == 3) sat2 = 1'b1;
    end
    @(posedge clk);
    #1;
    if (mode_moore) begin
      e = sb.pop_front();
      chk($sformatf("%s.%0d moore z", ctx, sn), 32'(z1), 32'(e));
      chk($sformatf("%s.%0d moore z2", ctx, sn), 32'(z2), 32'(e));
    end
    chk_counts();
    @(negedge clk);
  endtask

  // Beats taken MSB-first from bits; ms marks which beats must match.
  task automatic stream(input logic [31:0] bits, input logic [31:0] ms, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], ms[i]);
  endtask

  // Hold reset for a cycle with live beats; z must stay low in both modes.
  task automatic do_reset();
    rst_n      = 1'b0;
    din_valid  = 1'b1;
    din        = 1'b1;
    pat_load   = 1'b0;
    count_clr  = 1'b0;
    mode_moore = 1'b0;
    #1;
    chk({ctx, " rst mealy z"}, 32'(z1), 32'd0);
    chk({ctx, " rst count"}, 32'(cnt_o1), 32'd0);
    chk({ctx, " rst count2"}, 32'(cnt_o2), 32'd0);
    chk({ctx, " rst sat2"}, 32'(sat_o2), 32'd0);
    mode_moore = 1'b1;
    #1;
    chk({ctx, " rst moore z"}, 32'(z1), 32'd0);
    @(posedge clk);
    #1;
    chk({ctx, " rst moore z post-edge"}, 32'(z2), 32'd0);
    mode_moore = 1'b0;
    #1;
    chk({ctx, " rst mealy z post-edge"}, 32'(z1), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    din_valid = 1'b0;
    din       = 1'b0;
    cnt1      = 0;
    cnt2      = 0;
    sat2      = 1'b0;
    sb.delete();
  endtask

  initial begin
    logic [3:0] t3b;
    rst_n      = 1'b0;
    din_valid  = 1'b0;
    din        = 1'b0;
    pat_load   = 1'b0;
    count_clr  = 1'b0;
    mode_moore = 1'b0;
    overlap    = 1'b1;
    pattern    = 4'b0000;
    @(negedge clk);
    ctx = "reset";
    do_reset();

    // Default pattern, overlapping, Mealy.
    ctx = "t1";
    stream(32'b1101101, 32'b0001001, 7);
    chk("t1 final count", 32'(cnt_o1), 32'd2);

    // Non-overlapping, Mealy then Moore.
    ctx = "t2";
    pattern = 4'b1101;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    overlap = 1'b0;
    stream(32'b1101101, 32'b0001000, 7);
    step(1'b0, 1'b0, 1'b0);
    chk("t2 mealy count", 32'(cnt_o1), 32'd3);
    ctx = "t2m";
    mode_moore = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    stream(32'b1101101, 32'b0001000, 7);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    mode_moore = 1'b0;

    // Idle gaps with toggling din are transparent.
    ctx = "t3";
    overlap = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    t3b = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, t3b[i], 1'(i == 0));
      if (i != 0) repeat (3) step(1'b0, 1'b1, 1'b0);
    end

    // Pattern load mid-stream; load-cycle beat discarded.
    ctx = "t4";
    step(1'b0, 1'b0, 1'b0, 1'b1);
    stream(32'b110, 32'b000, 3);
    pattern = 4'b0110;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    stream(32'b0110, 32'b0001, 4);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    stream(32'b110, 32'b000, 3);
    step(1'b0, 1'b0, 1'b0);

    // Counter clear, saturation on the 2-bit instance, clear beats a match.
    ctx = "t5";
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    stream(32'b0110110110110, 32'b0001001001001, 13);
    chk("t5 sat count2", 32'(cnt_o2), 32'd3);
    chk("t5 sat flag2", 32'(sat_o2), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t5 clr-vs-match count2", 32'(cnt_o2), 32'd0);
    stream(32'b110, 32'b001, 3);
    chk("t5 after clr count2", 32'(cnt_o2), 32'd1);

    // Reset mid-sequence drops partial history and restores the default pattern.
    ctx = "t6";
    pattern = 4'b1101;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    stream(32'b110, 32'b000, 3);
    do_reset();
    stream(32'b11101, 32'b00001, 5);
    chk("t6 final count", 32'(cnt_o1), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
